// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: derives x/y and the active window from hsync/vsync
// and qualifies line/frame lengths against the nominal timing before reporting lock.
module vga_timing_receiver #(
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic        active_video,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        frame_start,
  output logic [11:0] h_total_meas,
  output logic [11:0] v_total_meas,
  output logic        sync_error
);

  localparam int unsigned GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT   = 12'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);
  localparam logic POL = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state;
  logic          hs, vs, hs_q, vs_q;
  logic          hs_edge, vs_edge, vs_pend;
  logic [11:0]   h_cnt, v_cnt, h_next, v_next;
  logic [GW-1:0] good_cnt, good_inc;
  logic          line_err, line_err_seen;
  logic          boundary, frame_good, timeout;
  logic          h_in, v_in;
  logic [11:0]   x_full, y_full;

  always_comb begin
    hs         = hsync_in ^ POL;
    vs         = vsync_in ^ POL;
    hs_edge    = hs & ~hs_q;
    vs_edge    = vs & ~vs_q;
    h_next     = h_cnt + 12'd1;
    v_next     = v_cnt + 12'd1;
    good_inc   = good_cnt + GW'(1);
    line_err   = hs_edge && (state != SEARCH) && (h_next != H_TOT);
    boundary   = hs_edge && (vs_pend || vs_edge);
    // The line ending at the boundary belongs to the frame being judged.
    frame_good = (v_next == V_TOT) && !line_err_seen && !line_err;
    // Fires on the step into saturation, so a stalled hsync reports once.
    timeout    = !hs_edge && (h_cnt == 12'hFFE);
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      vs_pend       <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      h_total_meas  <= '0;
      v_total_meas  <= '0;
      line_err_seen <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;

      if (hs_edge) begin
        h_cnt        <= '0;
        h_total_meas <= h_next;
      end else if (h_cnt != '1) begin
        h_cnt <= h_next;
      end

      if (boundary) begin
        v_cnt        <= '0;
        v_total_meas <= v_next;
        vs_pend      <= 1'b0;
      end else begin
        if (hs_edge && (v_cnt != '1)) v_cnt <= v_next;
        if (vs_edge) vs_pend <= 1'b1;
      end

      line_err_seen <= boundary ? 1'b0 : (line_err_seen | line_err);
    end
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      sync_error <= 1'b0;
    end else begin
      sync_error <= 1'b0;
      if (timeout) begin
        state      <= SEARCH;
        good_cnt   <= '0;
        sync_error <= 1'b1;
      end else begin
        case (state)
          SEARCH: begin
            if (boundary) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (boundary) begin
              if (frame_good) begin
                good_cnt <= good_inc;
                if (good_inc >= LOCK_N) state <= LOCKED;
              end else begin
                good_cnt   <= '0;
                sync_error <= 1'b1;
              end
            end else if (line_err) begin
              sync_error <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_err || (boundary && !frame_good)) begin
              state      <= SEARCH;
              good_cnt   <= '0;
              sync_error <= 1'b1;
            end
          end
          default: begin
            state    <= SEARCH;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    locked       = (state == LOCKED);
    h_in         = (h_cnt >= H_START) && (h_cnt <= H_END);
    v_in         = (v_cnt >= V_START) && (v_cnt <= V_END);
    active_video = locked && h_in && v_in;
    x_full       = h_cnt - H_START;
    y_full       = v_cnt - V_START;
    x_pos        = active_video ? x_full[9:0] : '0;
    y_pos        = active_video ? y_full[9:0] : '0;
    frame_start  = active_video && (x_pos == '0) && (y_pos == '0);
  end

endmodule
